// File: rtl/search_feeder_if.sv
// Byte stream into the search feeder: valid/ready handshake carrying data and
// an end-of-frame flag.
interface search_feeder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/search_feeder.sv
// Upstream sequencer for the mk_SEARCH pattern-count stage. Buffers bytes in a
// small FIFO, issues each one to the search stage with a one-cycle start code,
// samples num_matches a fixed latency later and accumulates per-frame totals.
//
// state | meaning
// IDLE  | waiting for a buffered byte; pops it into data_r/last_r when present
// ISSUE | search_control = 01 for this single cycle, wait counter loaded
// WAIT  | search_control = 00, counting down to the num_matches sample edge
module search_feeder #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  search_feeder_if.slave in_if,
  input  logic         cfg_load,
  input  logic [3:0]   cfg_str,
  output logic [3:0]   str,
  output logic [7:0]   data,
  output logic [1:0]   search_control,
  input  logic [7:0]   num_matches,
  output logic         busy,
  output logic         frame_valid,
  output logic [15:0]  frame_total,
  output logic [7:0]   frame_words
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state;
  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [8:0]      rd_entry;

  logic [7:0]      data_r;
  logic            last_r;
  logic [3:0]      str_r;
  logic [CW-1:0]   wait_cnt;
  logic [15:0]     acc;
  logic [7:0]      wcnt;
  logic [16:0]     acc_sum;
  logic [15:0]     acc_next;
  logic [7:0]      wcnt_next;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  // Ready comes from the pre-pop count, so a full FIFO never accepts even if
  // the FSM pops on the same edge.
  assign in_if.in_ready = !full;
  assign push     = in_if.in_valid && !full;
  assign pop      = (state == IDLE) && !empty;
  assign rd_entry = mem[rd_ptr];

  assign acc_sum   = {1'b0, acc} + {9'b0, num_matches};
  assign acc_next  = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
  assign wcnt_next = (wcnt == 8'hFF) ? 8'hFF : wcnt + 8'd1;

  assign data = data_r;
  assign str  = str_r;
  assign busy = (state != IDLE) || !empty;

  // FIFO storage; entries are {last, data}.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {in_if.in_last, in_if.in_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Pattern register only changes between frames, never while work is pending.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) str_r <= 4'h0;
    else if (cfg_load && (state == IDLE) && empty) str_r <= cfg_str;
  end

  // Issue/wait sequencer with accumulation and frame-end reporting.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= IDLE;
      data_r         <= 8'h00;
      last_r         <= 1'b0;
      search_control <= 2'b00;
      wait_cnt       <= '0;
      acc            <= 16'h0000;
      wcnt           <= 8'h00;
      frame_valid    <= 1'b0;
      frame_total    <= 16'h0000;
      frame_words    <= 8'h00;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            data_r         <= rd_entry[7:0];
            last_r         <= rd_entry[8];
            search_control <= 2'b01;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          search_control <= 2'b00;
          wait_cnt       <= CW'(LATENCY);
          state          <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == CW'(1)) begin
            wait_cnt <= '0;
            state    <= IDLE;
            if (last_r) begin
              // Clearing here lets the next frame's first byte pop right away
              // without inheriting anything from this one.
              frame_total <= acc_next;
              frame_words <= wcnt_next;
              frame_valid <= 1'b1;
              acc         <= 16'h0000;
              wcnt        <= 8'h00;
            end else begin
              acc  <= acc_next;
              wcnt <= wcnt_next;
            end
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        default: begin
          search_control <= 2'b00;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_search_feeder.sv
// Bench for search_feeder: directed stimulus with a scoreboard. Stimulus pushes
// expected issue bytes and frame results into queues; a negedge monitor pops
// and compares whenever the DUT issues a byte or strobes frame_valid. The
// monitor also plays the search stage, returning queued match counts.
module tb_search_feeder;
  localparam int LATENCY = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cfg_load;
  logic [3:0]  cfg_str;
  logic [3:0]  str;
  logic [7:0]  data;
  logic [1:0]  search_control;
  logic [7:0]  num_matches;
  logic        busy;
  logic        frame_valid;
  logic [15:0] frame_total;
  logic [7:0]  frame_words;

  search_feeder_if in_if ();

  search_feeder #(.DEPTH(4), .LATENCY(LATENCY)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .in_if          (in_if),
    .cfg_load       (cfg_load),
    .cfg_str        (cfg_str),
    .str            (str),
    .data           (data),
    .search_control (search_control),
    .num_matches    (num_matches),
    .busy           (busy),
    .frame_valid    (frame_valid),
    .frame_total    (frame_total),
    .frame_words    (frame_words)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [7:0]  exp_data_q [$];
  logic [23:0] exp_frame_q [$];
  logic [7:0]  resp_q [$];
  int          issue_cyc [$];
  logic [7:0]  hold_data;
  int          hold_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc++;

  // Monitor and search-stage model.
  always @(negedge CLK) begin
    if (!RST_N) begin
      hold_left = 0;
    end else begin
      if (search_control == 2'b01) begin
        issue_cyc.push_back(cyc);
        if (exp_data_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL issue_unexpected: got data 0x%0h expected no issue", data);
        end else begin
          check("issue_data", {24'h0, data}, {24'h0, exp_data_q.pop_front()});
        end
        hold_data = data;
        hold_left = LATENCY;
        num_matches = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
      end else if (hold_left > 0) begin
        check("data_hold", {24'h0, data}, {24'h0, hold_data});
        hold_left--;
      end
      if (frame_valid) begin
        if (exp_frame_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_unexpected: got total 0x%0h words 0x%0h expected no frame",
                   frame_total, frame_words);
        end else begin
          check("frame_result", {8'h0, frame_total, frame_words}, {8'h0, exp_frame_q.pop_front()});
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge CLK);
    in_if.in_valid = 1'b1;
    in_if.in_data  = d;
    in_if.in_last  = l;
    while (!in_if.in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!in_if.in_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got in_ready 0 expected 1 within 50 cycles");
    end else begin
      exp_data_q.push_back(d);
      @(posedge CLK);
    end
    #1 in_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge CLK);
    while ((busy || exp_frame_q.size() != 0 || exp_data_q.size() != 0) && n < limit) begin
      @(negedge CLK);
      n++;
    end
    if (n >= limit) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: got busy %0d pending frames %0d expected idle", busy, exp_frame_q.size());
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic load_pattern(input logic [3:0] p);
    @(negedge CLK);
    cfg_load = 1'b1;
    cfg_str  = p;
    @(negedge CLK);
    cfg_load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_str"}, {28'h0, str}, 32'h0);
    check({tag, "_data"}, {24'h0, data}, 32'h0);
    check({tag, "_search_control"}, {30'h0, search_control}, 32'h0);
    check({tag, "_frame_valid"}, {31'h0, frame_valid}, 32'h0);
    check({tag, "_frame_total"}, {16'h0, frame_total}, 32'h0);
    check({tag, "_frame_words"}, {24'h0, frame_words}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_in_ready"}, {31'h0, in_if.in_ready}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nextv;
    int         accepted;
    logic       ready_e6;
    logic       busy_at_load;
    int         n;

    in_if.in_valid = 1'b0;
    in_if.in_data  = 8'h00;
    in_if.in_last  = 1'b0;
    cfg_load       = 1'b0;
    cfg_str        = 4'h0;
    num_matches    = 8'h00;

    // Reset state
    #23;
    check_reset_outputs("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Single-byte frame
    load_pattern(4'b1001);
    check("str_initial_load", {28'h0, str}, 32'h9);
    resp_q.push_back(8'd1);
    exp_frame_q.push_back({16'd1, 8'd1});
    push_byte(8'h25, 1'b1);
    wait_idle(100);

    // Three-byte frame: 2 + 0 + 3
    issue_cyc.delete();
    resp_q.push_back(8'd2);
    resp_q.push_back(8'd0);
    resp_q.push_back(8'd3);
    exp_frame_q.push_back({16'd5, 8'd3});
    push_byte(8'hA1, 1'b0);
    push_byte(8'hA2, 1'b0);
    push_byte(8'hA3, 1'b1);
    wait_idle(100);
    check("issue_count_3byte", issue_cyc.size(), 32'd3);
    if (issue_cyc.size() == 3) begin
      check("issue_spacing_1", issue_cyc[1] - issue_cyc[0], 32'd4);
      check("issue_spacing_2", issue_cyc[2] - issue_cyc[1], 32'd4);
    end

    // FIFO full: valid held for 8 cycles, 6 accepted, ready low before the 6th edge
    nextv    = 8'h40;
    accepted = 0;
    ready_e6 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      in_if.in_valid = 1'b1;
      in_if.in_data  = nextv;
      in_if.in_last  = 1'b0;
      if (i == 5) ready_e6 = in_if.in_ready;
      if (in_if.in_ready) begin
        exp_data_q.push_back(nextv);
        nextv = nextv + 8'd1;
        accepted++;
      end
    end
    @(posedge CLK);
    #1 in_if.in_valid = 1'b0;
    check("fifo_full_ready", {31'h0, ready_e6}, 32'h0);
    check("fifo_full_accepted", accepted, 32'd6);
    exp_frame_q.push_back({16'd0, 8'd7});
    push_byte(nextv, 1'b1);
    wait_idle(200);

    // Saturation: 300 bytes at 255 matches each
    for (int i = 0; i < 300; i++) resp_q.push_back(8'd255);
    exp_frame_q.push_back({16'hFFFF, 8'hFF});
    for (int i = 0; i < 300; i++) push_byte(i[7:0], (i == 299));
    wait_idle(2000);

    // Pattern lock while busy, then accepted when idle
    exp_frame_q.push_back({16'd0, 8'd1});
    push_byte(8'h77, 1'b1);
    busy_at_load = busy;
    load_pattern(4'b1000);
    check("busy_during_load", {31'h0, busy_at_load}, 32'h1);
    check("str_locked", {28'h0, str}, 32'h9);
    wait_idle(100);
    load_pattern(4'b1000);
    check("str_unlocked", {28'h0, str}, 32'h8);

    // Mid-frame reset during WAIT
    resp_q.push_back(8'd9);
    push_byte(8'h99, 1'b1);
    n = 0;
    while (search_control != 2'b01 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("issue_before_reset", {30'h0, search_control}, 32'h1);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge CLK);
    RST_N = 1'b1;
    resp_q.push_back(8'd4);
    exp_frame_q.push_back({16'd4, 8'd1});
    push_byte(8'h31, 1'b1);
    wait_idle(100);

    check("leftover_issues", exp_data_q.size(), 32'd0);
    check("leftover_frames", exp_frame_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
